collatz_sweep: RTL

Sequencer that sits directly upstream and downstream of the generated `tests_collatz` core. It issues consecutive starting values to the core and collects the step count returned for each. It keeps the running maximum, the argument that produced it, and the sum over the sweep. This replaces hand-driven stimulus with a self-contained, synthesizable driver for batch runs on hardware.

---
 rtl/collatz_sweep_pkg.sv | 9 +
 rtl/collatz_sweep_stats.sv | 54 +++++
 rtl/collatz_sweep.sv | 122 ++++++++++++
 3 files changed

// File: rtl/collatz_sweep_pkg.sv
// Shared definitions for the collatz_sweep sequencer: FSM state encodings.
package collatz_sweep_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/collatz_sweep_stats.sv
// Running max / argmax / sum accumulator over the results of one sweep.
module collatz_sweep_stats #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           upd,
  input  logic [N-1:0]   arg,
  input  logic [N-1:0]   val,
  output logic [N-1:0]   best_arg,
  output logic [N-1:0]   best_val,
  output logic [2*N-1:0] sum
);

  logic [N-1:0]   best_arg_q, best_arg_d;
  logic [N-1:0]   best_val_q, best_val_d;
  logic [2*N-1:0] sum_q, sum_d;

  always_comb begin
    best_arg_d = best_arg_q;
    best_val_d = best_val_q;
    sum_d      = sum_q;
    if (clear) begin
      best_arg_d = '0;
      best_val_d = '0;
      sum_d      = '0;
    end else if (upd) begin
      sum_d = sum_q + {{N{1'b0}}, val};
      // Strict compare: on a tie the earlier argument is kept.
      if (val > best_val_q) begin
        best_val_d = val;
        best_arg_d = arg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_arg_q <= '0;
      best_val_q <= '0;
      sum_q      <= '0;
    end else begin
      best_arg_q <= best_arg_d;
      best_val_q <= best_val_d;
      sum_q      <= sum_d;
    end
  end

  assign best_arg = best_arg_q;
  assign best_val = best_val_q;
  assign sum      = sum_q;

endmodule

// File: rtl/collatz_sweep.sv
// Sweep driver for the collatz core: issues FIRST..FIRST+COUNT-1, collects
// step counts, and tracks max/argmax/sum with a per-request watchdog.
module collatz_sweep
  import collatz_sweep_pkg::*;
#(
  parameter int N       = 16,
  parameter int FIRST   = 1,
  parameter int COUNT   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           req_valid,
  input  logic           req_ready,
  output logic [N-1:0]   req_data,
  input  logic           resp_valid,
  input  logic [N-1:0]   resp_data,
  output logic [N-1:0]   best_arg,
  output logic [N-1:0]   best_val,
  output logic [2*N-1:0] sum
);

  localparam int LW = $clog2(COUNT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  cur_q, cur_d;
  logic [LW-1:0] left_q, left_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  logic          busy_q, done_q, req_valid_q;
  logic          clear, upd;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    left_d  = left_q;
    wd_d    = wd_q;
    err_d   = err_q;
    clear   = 1'b0;
    upd     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          err_d   = 1'b0;
          wd_d    = '0;
          cur_d   = N'(FIRST);
          left_d  = LW'(COUNT);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          wd_d    = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (resp_valid) begin
          upd     = 1'b1;
          cur_d   = cur_q + N'(1);
          left_d  = left_q - LW'(1);
          state_d = (left_q == LW'(1)) ? ST_DONE : ST_ISSUE;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      left_q      <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      left_q      <= left_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      req_valid_q <= (state_d == ST_ISSUE);
    end
  end

  collatz_sweep_stats #(.N(N)) u_stats (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .upd      (upd),
    .arg      (cur_q),
    .val      (resp_data),
    .best_arg (best_arg),
    .best_val (best_val),
    .sum      (sum)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_valid = req_valid_q;
  assign req_data  = cur_q;

endmodule
